// File: rtl/vga_pkg.sv
// Shared geometry, pipeline phase and attribute-layout definitions for the
// VGA text-mode glyph pipeline.
package vga_pkg;

  // Character cell and screen geometry
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CHAR_H    = 16;
  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;

  // Per-slot pipeline phases of the 3-bit phase counter
  localparam logic [2:0] P_ADDR  = 3'd0;
  localparam logic [2:0] P_LATCH = 3'd1;
  localparam logic [2:0] P_FONT  = 3'd2;
  localparam logic [2:0] P_LOAD  = 3'd3;

  // frame_cnt bit that drives blinking (toggles every 16 frames)
  localparam int unsigned BLINK_BIT = 4;

  // Attribute byte field positions
  localparam int unsigned ATTR_FG_LSB = 0;
  localparam int unsigned ATTR_FG_MSB = 3;
  localparam int unsigned ATTR_BG_LSB = 4;
  localparam int unsigned ATTR_BG_MSB = 6;
  localparam int unsigned ATTR_BLINK  = 7;

  typedef struct packed {
    logic       blink;  // [7]
    logic [2:0] bg;     // [6:4] background RGB, intensity always 0
    logic [3:0] fg;     // [3:0] foreground RGBI
  } attr_t;

endpackage

// File: rtl/vga_blink_gen.sv
// Blink generator: counts vsync rising edges and exposes a slow blink phase.
// Ports:
//   clk      - pixel clock
//   rst      - synchronous active-high reset
//   vsync    - vertical sync pulse, active high
//   blink_on - high for 16 frames, low for 16 frames
module vga_blink_gen
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic blink_on
);

  logic       vsync_q;
  logic [4:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      frame_cnt <= 5'd0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  assign blink_on = frame_cnt[BLINK_BIT];

endmodule

// File: rtl/vga_glyph_pipe.sv
// Text-mode pixel pipeline: fetches character/attribute bytes, looks up the
// glyph row in a synchronous font ROM and shifts 8 pixels per cell out as a
// 4-bit RGBI colour index.
// Ports:
//   clk         - pixel clock
//   rst         - synchronous active-high reset
//   n_pixel_ena - low inside the visible area
//   n_ccol_rst  - low for 4 clocks before the first pixel of each line
//   vy          - current line number
//   vsync       - vertical sync, active high
//   text_d      - text RAM data (async RAM)
//   color_d     - colour RAM data (async RAM)
//   font_d      - font ROM data (sync ROM)
//   ram_a       - text/colour RAM address {vy[8:4], col}
//   font_a      - font ROM address {char, vy[3:0]}
//   rgbi        - pixel colour index, 0 when blanked
module vga_glyph_pipe
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        n_pixel_ena,
  input  logic        n_ccol_rst,
  input  logic [9:0]  vy,
  input  logic        vsync,
  input  logic [7:0]  text_d,
  input  logic [7:0]  color_d,
  input  logic [7:0]  font_d,
  output logic [11:0] ram_a,
  output logic [11:0] font_a,
  output logic [3:0]  rgbi
);

  logic [2:0]        p_q;
  logic [6:0]        col_q;
  logic [7:0]        char_q;
  attr_t             attr_q;
  attr_t             attr_s_q;
  logic [CHAR_W-1:0] shift_q;
  logic              blink_on;
  logic [3:0]        fg;
  logic [3:0]        bg;
  logic              unused_vy;

  assign unused_vy = vy[9];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= 3'd0;
      col_q    <= 7'd0;
      char_q   <= 8'd0;
      attr_q   <= '0;
      attr_s_q <= '0;
      shift_q  <= '0;
    end else begin
      if (!n_ccol_rst) begin
        p_q     <= 3'd0;
        col_q   <= 7'd0;
        shift_q <= '0;
      end else begin
        p_q <= p_q + 3'd1;
        if (p_q == P_LOAD) begin
          // Glyph row arrives while the previous cell's last pixel is shown
          col_q    <= col_q + 7'd1;
          shift_q  <= font_d;
          attr_s_q <= attr_q;
        end else begin
          shift_q <= {shift_q[CHAR_W-2:0], 1'b0};
        end
      end
      if (p_q == P_LATCH) begin
        char_q <= text_d;
        attr_q <= color_d;
      end
    end
  end

  vga_blink_gen u_blink (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .blink_on (blink_on)
  );

  assign ram_a  = {vy[8:4], col_q};
  assign font_a = {char_q, vy[$clog2(CHAR_H)-1:0]};

  always_comb begin
    bg   = {1'b0, attr_s_q.bg};
    fg   = (attr_s_q.blink && blink_on) ? bg : attr_s_q.fg;
    rgbi = 4'h0;
    if (!n_pixel_ena) begin
      rgbi = shift_q[CHAR_W-1] ? fg : bg;
    end
  end

endmodule

// File: tb/tb_vga_glyph_pipe.sv
// Directed bench for vga_glyph_pipe with a pixel scoreboard.
module tb_vga_glyph_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_pixel_ena;
  logic        n_ccol_rst;
  logic [9:0]  vy;
  logic        vsync;
  logic [7:0]  text_d;
  logic [7:0]  color_d;
  logic [7:0]  font_d;
  logic [11:0] ram_a;
  logic [11:0] font_a;
  logic [3:0]  rgbi;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  // Memory model configuration
  logic       text_by_col   = 1'b0;
  logic [7:0] fix_char      = 8'h00;
  logic [7:0] fix_color     = 8'h00;
  logic       font_all_ones = 1'b0;
  logic [4:0] frame_m       = 5'd0;

  always #5 clk = ~clk;

  vga_glyph_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .n_pixel_ena (n_pixel_ena),
    .n_ccol_rst  (n_ccol_rst),
    .vy          (vy),
    .vsync       (vsync),
    .text_d      (text_d),
    .color_d     (color_d),
    .font_d      (font_d),
    .ram_a       (ram_a),
    .font_a      (font_a),
    .rgbi        (rgbi)
  );

  function automatic logic [7:0] text_of(input logic [6:0] c);
    return text_by_col ? {1'b0, c} : fix_char;
  endfunction

  function automatic logic [7:0] rom_of(input logic [11:0] a);
    if (font_all_ones) return 8'hFF;
    if (a == 12'h415) return 8'hA5;
    return a[11:4] ^ {a[3:0], 4'h9};
  endfunction

  function automatic logic [3:0] pix(input logic [7:0] ch, input logic [7:0] at,
                                     input logic [3:0] row, input int b);
    logic [7:0] g;
    logic [3:0] fgc;
    logic [3:0] bgc;
    g   = rom_of({ch, row});
    bgc = {1'b0, at[6:4]};
    fgc = (at[7] && frame_m[4]) ? bgc : at[3:0];
    return g[7-b] ? fgc : bgc;
  endfunction

  // Asynchronous text/colour RAM, synchronous font ROM
  assign text_d  = text_of(ram_a[6:0]);
  assign color_d = fix_color;
  always @(posedge clk) font_d <= rom_of(font_a);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_pix(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected pending pixel", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {8'h0, rgbi}, {8'h0, e});
    end
  endtask

  task automatic push_line(input int ncols, input int blank_col);
    for (int c = 0; c < ncols; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (c == blank_col) exp_q.push_back(4'h0);
        else exp_q.push_back(pix(text_of(7'(c)), fix_color, vy[3:0], b));
      end
    end
  endtask

  // One scan line: 4-clock n_ccol_rst window (optionally with vsync), 4 lead-in
  // clocks, then ncols visible cells; blank_col is driven with n_pixel_ena high.
  task automatic run_line(input int ncols, input bit vs, input int blank_col);
    n_pixel_ena = 1'b1;
    n_ccol_rst  = 1'b0;
    vsync       = vs;
    if (vs) frame_m = frame_m + 5'd1;
    push_line(ncols, blank_col);
    repeat (4) tick();
    n_ccol_rst = 1'b1;
    vsync      = 1'b0;
    // hx 140, p=0
    check("line_addr_col0", {5'h0, ram_a[6:0]}, 12'h0);
    check("line_addr_row", {7'h0, ram_a[11:7]}, {7'h0, vy[8:4]});
    check("lead_in_blank", {8'h0, rgbi}, 12'h0);
    tick();
    tick();
    // hx 142, p=2
    check("font_addr", font_a, {text_of(7'd0), vy[3:0]});
    tick();
    tick();
    for (int j = 0; j < ncols * 8; j++) begin
      n_pixel_ena = (j / 8 == blank_col);
      #1;
      check_pix("pixel");
      if (j % 8 == 4) check("sweep_addr", {5'h0, ram_a[6:0]}, 12'(j / 8 + 1));
      tick();
    end
    n_pixel_ena = 1'b1;
    #1;
    check("line_end_blank", {8'h0, rgbi}, 12'h0);
    repeat (4) tick();
  endtask

  initial begin
    rst         = 1'b1;
    n_pixel_ena = 1'b0;
    n_ccol_rst  = 1'b1;
    vsync       = 1'b0;
    vy          = 10'h2B7;
    repeat (2) tick();
    check("reset_rgbi", {8'h0, rgbi}, 12'h0);
    check("reset_ram_a_col", {5'h0, ram_a[6:0]}, 12'h0);
    check("reset_ram_a_row", {7'h0, ram_a[11:7]}, {7'h0, vy[8:4]});
    check("reset_font_a_char", {4'h0, font_a[11:4]}, 12'h0);
    check("reset_font_a_row", {8'h0, font_a[3:0]}, 12'h7);
    rst = 1'b0;
    n_pixel_ena = 1'b1;
    tick();

    // Single cell: glyph 0xA5 in colours F on 1
    vy        = 10'd5;
    fix_char  = 8'h41;
    fix_color = 8'h1F;
    run_line(1, 1'b0, -1);

    // Column sweep: text byte equals column, different colours
    vy          = 10'd37;
    text_by_col = 1'b1;
    fix_color   = 8'h2C;
    run_line(80, 1'b0, -1);

    // Blink: 0x9E over a solid glyph; vsync pulses coincide with n_ccol_rst.
    // Second cell of every 4th line is blanked while shift holds ones.
    text_by_col   = 1'b0;
    fix_color     = 8'h9E;
    font_all_ones = 1'b1;
    vy            = 10'd3;
    run_line(2, 1'b0, 1);
    for (int f = 1; f < 32; f++) begin
      run_line(2, 1'b1, (f % 4 == 0) ? 1 : -1);
    end

    // Resync: drop n_ccol_rst for one clock at p=5
    fix_color = 8'h1F;
    n_pixel_ena = 1'b1;
    n_ccol_rst  = 1'b0;
    repeat (4) tick();
    n_ccol_rst = 1'b1;
    repeat (4) tick();
    exp_q.push_back(4'hF);
    exp_q.push_back(4'hF);
    repeat (4) exp_q.push_back(4'h1);
    exp_q.push_back(4'hF);
    exp_q.push_back(4'hF);
    n_pixel_ena = 1'b0;
    #1;
    check_pix("resync_p4");
    tick();
    n_ccol_rst = 1'b0;
    #1;
    check_pix("resync_p5");
    tick();
    n_ccol_rst = 1'b1;
    #1;
    check("resync_col", {5'h0, ram_a[6:0]}, 12'h0);
    for (int k = 0; k < 6; k++) begin
      check_pix("resync_after");
      tick();
    end

    // Reset mid-line while visible
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    frame_m = 5'd0;
    #1;
    check("midline_reset_rgbi", {8'h0, rgbi}, 12'h0);
    check("midline_reset_col", {5'h0, ram_a[6:0]}, 12'h0);
    n_pixel_ena = 1'b1;
    tick();

    check("scoreboard_drained", 12'(exp_q.size()), 12'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
